// File: rtl/rv_m_pkg.sv
// Shared RV32M definitions: funct3 encodings, mul/div FSM states and the
// opcode/funct7 pair that identifies an M-extension instruction.
package rv_m_pkg;

    localparam logic [6:0] OP_M     = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/rv_muldiv_unit.sv
// Iterative RV-M multiply/divide for the EX stage: radix-2 shift-add multiply and
// restoring divide sharing one 2*XLEN shift register and iteration counter.
module rv_muldiv_unit
    import rv_m_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   src1_i,
    input  logic [XLEN-1:0]   src2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] rd_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_e           state, state_n;
    m_op_e               op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       cnt;
    logic                neg_q, dsgn_q, spec_q;

    logic                is_div, sgn1, sgn2, s1neg, s2neg, div0, ovf, special;
    logic [XLEN-1:0]     abs1, abs2, spec_res;
    logic [XLEN:0]       madd, dpart, dtrial;
    logic [2*XLEN-1:0]   step, prod;
    logic [XLEN-1:0]     quo, rem, fix_res;

    // Operand conditioning, evaluated in PREP on the raw operands latched at accept
    always_comb begin
        is_div  = op_q[2];
        sgn1    = op_q inside {M_MULH, M_MULHSU, M_DIV, M_REM};
        sgn2    = op_q inside {M_MULH, M_DIV, M_REM};
        s1neg   = sgn1 & a_q[XLEN-1];
        s2neg   = sgn2 & b_q[XLEN-1];
        abs1    = s1neg ? -a_q : a_q;
        abs2    = s2neg ? -b_q : b_q;
        div0    = is_div & (b_q == '0);
        ovf     = is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);
        special = div0 | ovf;
        if (div0) spec_res = op_q[1] ? a_q : '1;
        else      spec_res = op_q[1] ? '0 : a_q;
    end

    // One radix-2 iteration; the divide trial keeps the bit shifted out of the remainder
    always_comb begin
        madd   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        dpart  = acc[2*XLEN-1:XLEN-1];
        dtrial = dpart - {1'b0, b_q};
        if (is_div)
            step = dtrial[XLEN] ? {dpart[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            step = {madd, acc[XLEN-1:1]};
    end

    always_comb begin
        prod = neg_q  ? -acc : acc;
        quo  = neg_q  ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = dsgn_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            M_MUL:                     fix_res = prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             fix_res = quo;
            default:                   fix_res = rem;
        endcase
        if (spec_q) fix_res = acc[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (valid_i && !flush_i) state_n = S_PREP;
            S_PREP: state_n = flush_i ? S_IDLE : (special ? S_FIX : S_CALC);
            S_CALC: if (flush_i) state_n = S_IDLE;
                    else if (cnt == LAST) state_n = S_FIX;
            S_FIX:  state_n = flush_i ? S_IDLE : S_DONE;
            default: state_n = S_IDLE;
        endcase
        ready_o = (state == S_IDLE);
        stall_o = ((state == S_IDLE) & valid_i & ~flush_i) |
                  (state == S_PREP) | (state == S_CALC) | (state == S_FIX);
        done_o  = (state == S_DONE) & ~flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= M_MUL;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            dsgn_q   <= 1'b0;
            spec_q   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            case (state)
                S_IDLE: if (valid_i && !flush_i) begin
                    op_q <= m_op_e'(op_i);
                    rd_q <= rd_i;
                    a_q  <= src1_i;
                    b_q  <= src2_i;
                end
                S_PREP: begin
                    neg_q  <= s1neg ^ s2neg;
                    dsgn_q <= s1neg;
                    spec_q <= special;
                    b_q    <= abs2;
                    cnt    <= '0;
                    acc    <= {{XLEN{1'b0}}, special ? spec_res : abs1};
                end
                S_CALC: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: if (!flush_i) begin
                    result_o <= fix_res;
                    rd_o     <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomized and directed checks of rv_muldiv_unit at XLEN=32 and XLEN=16
// against an arithmetic reference model of the RV-M rules.
module tb_rv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, flush, sel16;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic [4:0]  rd;

    logic        ready32, stall32, done32, ready16, stall16, done16;
    logic [31:0] res32;
    logic [15:0] res16;
    logic [4:0]  rd32, rd16;

    logic        ready, stall, done;
    logic [31:0] res;
    logic [4:0]  rdo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.XLEN(32), .REG_AW(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid & ~sel16), .op_i(op),
        .src1_i(src1), .src2_i(src2), .rd_i(rd), .flush_i(flush),
        .ready_o(ready32), .stall_o(stall32), .done_o(done32),
        .result_o(res32), .rd_o(rd32)
    );

    rv_muldiv_unit #(.XLEN(16), .REG_AW(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid & sel16), .op_i(op),
        .src1_i(src1[15:0]), .src2_i(src2[15:0]), .rd_i(rd), .flush_i(flush),
        .ready_o(ready16), .stall_o(stall16), .done_o(done16),
        .result_o(res16), .rd_o(rd16)
    );

    assign ready = sel16 ? ready16 : ready32;
    assign stall = sel16 ? stall16 : stall32;
    assign done  = sel16 ? done16  : done32;
    assign res   = sel16 ? {16'h0, res16} : res32;
    assign rdo   = sel16 ? rd16 : rd32;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV-M semantics with wide integer arithmetic, width w in {16,32}
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        longint mask, mn, ua, ub, sa, sb, p;
        mask = (longint'(1) << w) - 1;
        mn   = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= mn) ? ua - (mask + 1) : ua;
        sb   = (ub >= mn) ? ub - (mask + 1) : ub;
        case (f3)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >> w;
            3'd2: p = (sa * ub) >> w;
            3'd3: p = (ua * ub) >> w;
            3'd4: p = (ub == 0) ? mask : ((ua == mn && ub == mask) ? mn : sa / sb);
            3'd5: p = (ub == 0) ? mask : ua / ub;
            3'd6: p = (ub == 0) ? ua : ((ua == mn && ub == mask) ? 0 : sa % sb);
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    // Issue one op; 'now' means the caller is already just after a rising edge.
    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit w16, input bit now,
                       input int flush_at, input int rst_at);
        int w, exp_cyc, done_cyc;
        logic [31:0] exp_res, mask, prev;
        bit special, bad_stall;
        w        = w16 ? 16 : 32;
        mask     = w16 ? 32'h0000FFFF : 32'hFFFFFFFF;
        exp_res  = ref_md(f3, a, b, w);
        special  = f3[2] && (((b & mask) == 0) ||
                   (!f3[0] && (a & mask) == (32'(1) << (w - 1)) && (b & mask) == mask));
        exp_cyc  = special ? 3 : w + 3;
        done_cyc = -1;
        bad_stall = 1'b0;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        sel16 = w16;
        prev  = res;
        valid = 1'b1; op = f3; src1 = a; src2 = b; rd = r;
        @(negedge clk);
        chk("accept_ready", {31'h0, ready}, 32'h1);
        chk("accept_stall", {31'h0, stall}, 32'h1);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                valid = 1'b0; op = 3'($urandom); src1 = $urandom; src2 = $urandom; rd = 5'($urandom);
            end
            if (c == flush_at) flush = 1'b1;
            if (flush_at > 0 && c == flush_at + 1) begin
                flush = 1'b0;
                chk("flush_ready", {31'h0, ready}, 32'h1);
                chk("flush_res", res, prev);
                return;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ready", {31'h0, ready32}, 32'h1);
                chk("rst_outs", {25'h0, done32, stall32, rd32}, 32'h0);
                chk("rst_res", res32, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                break;
            end
            if (!stall) bad_stall = 1'b1;
        end
        chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        chk("result", res, exp_res);
        chk("rd_tag", {27'h0, rdo}, {27'h0, r});
        chk("stall_busy", {31'h0, bad_stall}, 32'h0);
        chk("stall_done", {31'h0, stall}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; sel16 = 1'b0;
        op = 3'd0; src1 = '0; src2 = '0; rd = '0;
        #12;
        chk("reset_ready", {31'h0, ready32}, 32'h1);
        chk("reset_outs", {26'h0, done32, rd32}, 32'h0);
        chk("reset_res", res32, 32'h0);
        valid = 1'b1;
        #1;
        chk("reset_stall_follow", {31'h0, stall32}, 32'h1);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b0, 1'b0, 0, 0);
        chk("mul_neg3", res32, 32'hFFFFFFEB);
        run(3'd1, 32'h80000000, 32'h80000000, 5'd6, 1'b0, 1'b0, 0, 0);
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b0, 0, 0);
        run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1'b0, 1'b0, 0, 0);
        chk("mulhsu_val", res32, 32'hFFFFFFFF);
        run(3'd4, -32'sd7, 32'd2, 5'd9, 1'b0, 1'b0, 0, 0);
        chk("div_m7_2", res32, 32'hFFFFFFFD);
        run(3'd6, -32'sd7, 32'd2, 5'd10, 1'b0, 1'b0, 0, 0);
        run(3'd5, 32'd100, 32'd7, 5'd11, 1'b0, 1'b0, 0, 0);
        chk("divu_100_7", res32, 32'd14);
        run(3'd7, 32'd100, 32'd7, 5'd12, 1'b0, 1'b0, 0, 0);
        run(3'd4, 32'd5, 32'd0, 5'd13, 1'b0, 1'b0, 0, 0);
        run(3'd7, 32'd5, 32'd0, 5'd14, 1'b0, 1'b0, 0, 0);
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1'b0, 1'b0, 0, 0);
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b0, 1'b0, 0, 0);
        chk("rem_ovf", res32, 32'h0);

        run(3'd0, 32'h1234, 32'h5678, 5'd17, 1'b0, 1'b0, 10, 0);
        run(3'd5, 32'd1000, 32'd33, 5'd18, 1'b0, 1'b1, 0, 0);
        run(3'd1, 32'hDEADBEEF, 32'h12345678, 5'd19, 1'b0, 1'b0, 0, 15);
        run(3'd3, 32'h0000FFFF, 32'h0000FFFF, 5'd20, 1'b1, 1'b0, 0, 0);
        chk("mulhu16", res, 32'h0000FFFE);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rf3;
            logic [31:0] ra, rb;
            bit          r16;
            int          pick;
            rf3  = 3'($urandom_range(0, 7));
            r16  = ($urandom_range(0, 3) == 0);
            ra   = $urandom;
            rb   = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) rb = 32'h0;
            else if (pick == 1) begin
                ra = r16 ? 32'h00008000 : 32'h80000000;
                rb = 32'hFFFFFFFF;
            end else if (pick == 2) rb = $urandom_range(1, 9);
            run(rf3, ra, rb, 5'($urandom), r16, 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Iterative RV32M multiply/divide unit for the EX stage of the five-stage RISC-V pipeline, parametrised in data width. The EX stage issues a request with `valid_i`. The unit raises `stall_o` so the hazard/stall path freezes PC, IF/ID and ID/EX. It returns a registered result with rd tag for the EX/MEM register. It also honours pipeline flushes and reports a fixed, data-independent latency except for the RV-M special cases.

## Interface
- `XLEN`, 32, operand/result width (any even value ≥ 8)
- `REG_AW`, 5, register-address width

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous reset, active low
- `valid_i`  in  1  M-extension instruction present in EX
- `op_i`  in  3  funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111
- `src1_i`  in  XLEN  forwarded rs1 value
- `src2_i`  in  XLEN  forwarded rs2 value
- `rd_i`  in  REG_AW  destination register
- `flush_i`  in  1  kill in-flight or incoming operation
- `ready_o`  out  1  unit idle, request can be accepted
- `stall_o`  out  1  hold upstream pipeline
- `done_o`  out  1  one-cycle result-valid strobe
- `result_o`  out  XLEN  result, held until next completion
- `rd_o`  out  REG_AW  rd tag of `result_o`

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
  - IDLE→PREP on accept (`valid_i & ready_o & ~flush_i`).
  - PREP→CALC, or PREP→FIX directly for special cases.
  - CALC runs XLEN iterations, then →FIX.
  - FIX→DONE, then DONE→IDLE unconditionally.
- Accept latches `op_i` and `rd_i`. PREP takes absolute values of the signed operands and records the result sign.
- Operand sign rules:
  - MULH, DIV and REM treat both operands as signed.
  - MULHSU treats src1 as signed and src2 as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Multiply is radix-2 shift-add into a 2·XLEN accumulator, with a log2(XLEN)-bit iteration counter. FIX negates the product if the sign bit is set.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide is restoring radix-2 over XLEN iterations. FIX applies the signs:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend.
- Special cases are detected in PREP, bypass CALC, and FIX loads the preset result:
  - divisor 0: DIV/DIVU give all-ones; REM/REMU give src1;
  - signed overflow (DIV/REM with src1 = min and src2 = −1): DIV gives min, REM gives 0.
- `flush_i` behaviour:
  - in any non-IDLE state: next state IDLE, no `done_o`, `result_o` unchanged;
  - in IDLE: blocks acceptance;
  - in DONE: suppresses `done_o` (`done_o = DONE & ~flush_i`).
- `ready_o` = IDLE.
- `stall_o` = (IDLE & `valid_i` & ~`flush_i`) | PREP | CALC | FIX. It is low in DONE so the pipeline advances while capturing `result_o`.
- `result_o` and `rd_o` update on the FIX→DONE edge only.

## Timing
- Numbering: cycle 0 is the accept cycle.
  - Normal ops: PREP in cycle 1, CALC in cycles 2..XLEN+1, FIX in cycle XLEN+2, `done_o` in cycle XLEN+3 (35 at XLEN=32).
  - Special cases: PREP in cycle 1, FIX in cycle 2, `done_o` in cycle 3.
- `stall_o` is high in cycles 0 through (done cycle − 1).
- Earliest next accept is the cycle after DONE; there is no back-to-back accept in DONE.
- Reset values, applied immediately (including mid-operation):
  - state IDLE, so `ready_o` = 1 and `stall_o` follows `valid_i & ~flush_i`;
  - `done_o` 0, `result_o` 0, `rd_o` 0, counter 0, accumulators 0.
- Inputs are sampled only at accept; later changes on `src*_i` and `op_i` are ignored.

## Structure
- Shared package `rv_m_pkg` holds:
  - `m_op_e` enum (the eight funct3 encodings);
  - `md_state_e` enum;
  - opcode constant `OP_M = 7'b0110011` with `FUNCT7_M = 7'b0000001`, for decoder reuse.
- Single module with no sub-module. Multiply and divide share the 2·XLEN shift register and the counter.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> `result_o` 0xFFFFFFEB; `done_o` only in cycle 35; `stall_o` high in cycles 0–34; `rd_o` = `rd_i`.
- Three high-part multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Divide and remainder:
  - DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF;
  - DIVU 100/7 -> 14; REMU 100/7 -> 2; each completes in cycle 35.
- Special cases, each with `done_o` in cycle 3:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- `flush_i` in cycle 10 -> IDLE and `ready_o` = 1 in cycle 11, no `done_o`, `result_o` unchanged. A request in cycle 11 then completes normally in cycle 46.
- `rst_n` low during CALC -> all outputs at reset values before the next edge, `ready_o` = 1. With XLEN=16, MULHU 0xFFFF×0xFFFF -> 0xFFFE with `done_o` in cycle 19.
